axi4_lite_master: RTL and testbench
===================================

// Module: axi4_lite_master
// PURPOSE
//  Single-outstanding AXI4-Lite initiator. Turns a simple command/response handshake into AXI4-Lite
//  AW/W/B or AR/R transactions. Drives our axi4_lite register slaves from control logic and test harnesses.
//  Every AXI output is registered. One transaction is in flight at a time.
// PARAMETERS
//  ADDRESS_SIZE  4   width of cmd_addr / m_axi_awaddr / m_axi_araddr
//  DATA_SIZE     32  data width (multiple of 8); strobe width is DATA_SIZE/8
// PORTS
//  aclk           in   1               clock, all logic on rising edge
//  areset         in   1               synchronous active-high reset
//  cmd_valid      in   1               command offered
//  cmd_ready      out  1               command accepted when valid&ready
//  cmd_write      in   1               1=write, 0=read
//  cmd_addr       in   ADDRESS_SIZE    target address
//  cmd_wdata      in   DATA_SIZE       write data (ignored on read)
//  cmd_wstrb      in   DATA_SIZE/8     write byte strobes (ignored on read)
//  rsp_valid      out  1               response available
//  rsp_ready      in   1               response consumed when valid&ready
//  rsp_write      out  1               echo of cmd_write for this response
//  rsp_rdata      out  DATA_SIZE       read data (0 for writes)
//  rsp_resp       out  2               captured BRESP/RRESP
//  m_axi_awaddr/awvalid/awready   out/out/in   ADDRESS_SIZE/1/1   write address channel
//  m_axi_wdata/wstrb/wvalid/wready out/out/out/in DATA_SIZE/DATA_SIZE/8/1/1 write data channel
//  m_axi_bresp/bvalid/bready      in/in/out    2/1/1              write response channel
//  m_axi_araddr/arvalid/arready   out/out/in   ADDRESS_SIZE/1/1   read address channel
//  m_axi_rdata/rresp/rvalid/rready in/in/in/out DATA_SIZE/2/1/1   read data channel
// BEHAVIOUR
//  Reset: state=IDLE. cmd_ready=1. rsp_valid=0. awvalid=wvalid=arvalid=bready=rready=0.
//   Address/data/resp registers reset to 0. Reset mid-transaction abandons it immediately.
//  FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP. cmd_ready=1 only in IDLE.
//  IDLE: on cmd_valid, latch addr/wdata/wstrb/write.
//   If cmd_write=1, go to WR_REQ with awvalid=wvalid=1 next cycle.
//   If cmd_write=0, go to RD_REQ with arvalid=1 next cycle.
//  WR_REQ: AW and W are tracked independently, in any order or simultaneously.
//   Each valid drops the cycle after its own valid&ready. Payloads stay stable while valid.
//   When both handshakes are done (the last may be in the current cycle), go to WR_RESP with bready=1.
//  WR_RESP: on bvalid, capture bresp, set bready=0, go to RESP with rsp_valid=1. rsp_rdata=0.
//  RD_REQ: on arready, arvalid=0, go to RD_DATA with rready=1.
//  RD_DATA: on rvalid, capture rdata/rresp, set rready=0, go to RESP with rsp_valid=1.
//  RESP: rsp_* held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE with cmd_ready=1 next cycle.
//  Minimum latency with always-ready slave/consumer:
//   cmd accept at T, AW/W or AR handshake at T+1, B or R at T+2, rsp_valid at T+3, cmd_ready again at T+4.
//  Ready is never a precondition for valid: no valid waits on its ready. Valids are never withdrawn before handshake.
//  bready/rready are asserted only in WR_RESP/RD_DATA.
//   Spurious bvalid/rvalid in other states is ignored and captures nothing.
//  Error responses (SLVERR=2, DECERR=3) are passed through unchanged. No retry.
//  No timeout: a slave that never responds stalls the block until reset.
// TESTING
//  1 Write 0x4, data 0xDEADBEEF, strb 0xF, slave always ready, bresp=0
//    -> awaddr=0x4/wdata=0xDEADBEEF at T+1, rsp_valid at T+3, rsp_resp=0, rsp_write=1.
//  2 Read 0x8, slave returns 0x12345678, rresp=0
//    -> arvalid at T+1, rsp_rdata=0x12345678, rsp_resp=0, rsp_write=0.
//  3 Write with awready delayed 3 cycles, wready immediate
//    -> wvalid drops after 1 cycle, awvalid held 4 cycles with awaddr stable, bready only after both done.
//  4 Read with rresp=2'b10, rsp_ready held low 5 cycles
//    -> rsp_resp=2, rsp_* stable for 5 cycles, cmd_ready=0 throughout.
//  5 Back-to-back write then read, cmd_valid held high
//    -> second cmd accepted only after first rsp handshake. Exactly one AW, one W, one AR issued.
//  6 Assert areset while awvalid=1 and awready=0
//    -> next cycle all valids=0, bready=rready=0, cmd_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator.
// Converts a command/response handshake into one AW/W/B or AR/R transaction at a time.
// Every AXI-facing output comes straight from a flop.
module axi4_lite_master #(
   parameter int unsigned ADDRESS_SIZE = 4,
   parameter int unsigned DATA_SIZE    = 32
) (
   input  logic                      aclk_i,
   input  logic                      areset_i,
   // Command side
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [ADDRESS_SIZE-1:0]   cmd_addr_i,
   input  logic [DATA_SIZE-1:0]      cmd_wdata_i,
   input  logic [DATA_SIZE/8-1:0]    cmd_wstrb_i,
   // Response side
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic                      rsp_write_o,
   output logic [DATA_SIZE-1:0]      rsp_rdata_o,
   output logic [1:0]                rsp_resp_o,
   // Write address channel
   output logic [ADDRESS_SIZE-1:0]   m_axi_awaddr_o,
   output logic                      m_axi_awvalid_o,
   input  logic                      m_axi_awready_i,
   // Write data channel
   output logic [DATA_SIZE-1:0]      m_axi_wdata_o,
   output logic [DATA_SIZE/8-1:0]    m_axi_wstrb_o,
   output logic                      m_axi_wvalid_o,
   input  logic                      m_axi_wready_i,
   // Write response channel
   input  logic [1:0]                m_axi_bresp_i,
   input  logic                      m_axi_bvalid_i,
   output logic                      m_axi_bready_o,
   // Read address channel
   output logic [ADDRESS_SIZE-1:0]   m_axi_araddr_o,
   output logic                      m_axi_arvalid_o,
   input  logic                      m_axi_arready_i,
   // Read data channel
   input  logic [DATA_SIZE-1:0]      m_axi_rdata_i,
   input  logic [1:0]                m_axi_rresp_i,
   input  logic                      m_axi_rvalid_i,
   output logic                      m_axi_rready_o
);

   localparam int unsigned StrbSize = DATA_SIZE / 8;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdData,
      StResp
   } state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_SIZE-1:0]  addr_q, addr_d;
   logic [DATA_SIZE-1:0]     wdata_q, wdata_d;
   logic [StrbSize-1:0]      wstrb_q, wstrb_d;
   logic                     write_q, write_d;
   logic [DATA_SIZE-1:0]     rdata_q, rdata_d;
   logic [1:0]               resp_q, resp_d;
   logic                     awvalid_q, awvalid_d;
   logic                     wvalid_q, wvalid_d;
   logic                     arvalid_q, arvalid_d;
   logic                     bready_q, bready_d;
   logic                     rready_q, rready_d;
   logic                     rsp_valid_q, rsp_valid_d;

   // A write channel counts as done once its valid has dropped or is handshaking now.
   logic aw_done, w_done;

   // Next-state and next-output logic for the transaction FSM.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      write_d     = write_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      aw_done     = !awvalid_q || m_axi_awready_i;
      w_done      = !wvalid_q || m_axi_wready_i;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               addr_d  = cmd_addr_i;
               wdata_d = cmd_wdata_i;
               wstrb_d = cmd_wstrb_i;
               write_d = cmd_write_i;
               if (cmd_write_i) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = StWrReq;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = StRdReq;
               end
            end
         end

         StWrReq: begin
            if (awvalid_q && m_axi_awready_i) begin
               awvalid_d = 1'b0;
            end
            if (wvalid_q && m_axi_wready_i) begin
               wvalid_d = 1'b0;
            end
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               state_d  = StWrResp;
            end
         end

         StWrResp: begin
            if (m_axi_bvalid_i) begin
               resp_d      = m_axi_bresp_i;
               rdata_d     = '0;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end
         end

         StRdReq: begin
            if (m_axi_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdData;
            end
         end

         StRdData: begin
            if (m_axi_rvalid_i) begin
               rdata_d     = m_axi_rdata_i;
               resp_d      = m_axi_rresp_i;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end
         end

         StResp: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end

         default: begin
            // Unreachable encodings fall back to a clean idle.
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b0;
            state_d     = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset drops any transaction in flight.
   always_ff @(posedge aclk_i) begin
      if (areset_i) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         write_q     <= 1'b0;
         rdata_q     <= '0;
         resp_q      <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         write_q     <= write_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign cmd_ready_o     = (state_q == StIdle);
   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_write_o     = write_q;
   assign rsp_rdata_o     = rdata_q;
   assign rsp_resp_o      = resp_q;
   assign m_axi_awaddr_o  = addr_q;
   assign m_axi_awvalid_o = awvalid_q;
   assign m_axi_wdata_o   = wdata_q;
   assign m_axi_wstrb_o   = wstrb_q;
   assign m_axi_wvalid_o  = wvalid_q;
   assign m_axi_bready_o  = bready_q;
   assign m_axi_araddr_o  = addr_q;
   assign m_axi_arvalid_o = arvalid_q;
   assign m_axi_rready_o  = rready_q;

   // Valids stay up with a stable payload until their handshake.
   a_aw_hold : assert property (@(posedge aclk_i) disable iff (areset_i)
      (m_axi_awvalid_o && !m_axi_awready_i) |=> (m_axi_awvalid_o && $stable(m_axi_awaddr_o)));
   a_w_hold : assert property (@(posedge aclk_i) disable iff (areset_i)
      (m_axi_wvalid_o && !m_axi_wready_i) |=> (m_axi_wvalid_o && $stable(m_axi_wdata_o)));
   a_ar_hold : assert property (@(posedge aclk_i) disable iff (areset_i)
      (m_axi_arvalid_o && !m_axi_arready_i) |=> (m_axi_arvalid_o && $stable(m_axi_araddr_o)));
   a_rsp_hold : assert property (@(posedge aclk_i) disable iff (areset_i)
      (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_rdata_o)
                                         && $stable(rsp_resp_o)));

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: directed transactions against a configurable slave/consumer,
// a transaction-level obligation model checked every cycle, and hand-computed timing pins.
module tb_axi4_lite_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        cmd_ready, rsp_valid, rsp_write;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [3:0]  awaddr, araddr;
   logic        awvalid, wvalid, arvalid, bready, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = '0, rresp = '0;
   logic [31:0] rdata = '0;

   axi4_lite_master #(.ADDRESS_SIZE(4), .DATA_SIZE(32)) dut (
      .aclk_i(clk), .areset_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
      .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
      .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
      .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wvalid_o(wvalid),
      .m_axi_wready_i(wready),
      .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
      .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
      .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rvalid_i(rvalid),
      .m_axi_rready_o(rready)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave / consumer configuration
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0, rsp_delay = 0;
   logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
   logic [31:0] rdata_cfg = 32'h0;
   bit          spur = 1'b0;

   // Obligation model: what the master owes the bus after each observed event.
   bit          started = 1'b0;
   bit          idle_m, aw_owed, w_owed, ar_owed, b_owed, r_owed, rsp_due, wr_phase;
   logic [3:0]  cur_addr;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_wstrb;
   logic        exp_write;
   logic [31:0] exp_rdata;
   logic [1:0]  exp_resp;

   // Event counters, timestamps and captures
   int          cyc = 0;
   int          n_cmd = 0, n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_rsp = 0;
   int          t_cmd, t_aw, t_w, t_ar, t_b, t_r, t_rsp;
   int          aw_hi = 0, w_hi = 0, rsp_hi = 0;
   logic [3:0]  cap_awaddr, cap_araddr, cap_wstrb;
   logic [31:0] cap_wdata, cap_rsp_rdata;
   logic [1:0]  cap_rsp_resp;
   logic        cap_rsp_write;

   // Observe handshakes on the rising edge and advance the model.
   initial begin : monitor
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            started = 1'b1;
            idle_m = 1'b1; aw_owed = 1'b0; w_owed = 1'b0; ar_owed = 1'b0;
            b_owed = 1'b0; r_owed = 1'b0; rsp_due = 1'b0; wr_phase = 1'b0;
         end else if (started) begin
            if (awvalid === 1'b1) aw_hi++;
            if (wvalid === 1'b1) w_hi++;
            if (rsp_valid === 1'b1) rsp_hi++;
            if (bvalid && bready === 1'b1) begin
               n_b++; t_b = cyc; b_owed = 1'b0; rsp_due = 1'b1;
               exp_write = 1'b1; exp_rdata = 32'h0; exp_resp = bresp;
            end
            if (rvalid && rready === 1'b1) begin
               n_r++; t_r = cyc; r_owed = 1'b0; rsp_due = 1'b1;
               exp_write = 1'b0; exp_rdata = rdata; exp_resp = rresp;
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
               n_rsp++; t_rsp = cyc; rsp_due = 1'b0; idle_m = 1'b1;
               cap_rsp_rdata = rsp_rdata; cap_rsp_resp = rsp_resp; cap_rsp_write = rsp_write;
            end
            if (awvalid === 1'b1 && awready) begin
               n_aw++; t_aw = cyc; cap_awaddr = awaddr; aw_owed = 1'b0;
            end
            if (wvalid === 1'b1 && wready) begin
               n_w++; t_w = cyc; cap_wdata = wdata; cap_wstrb = wstrb; w_owed = 1'b0;
            end
            if (arvalid === 1'b1 && arready) begin
               n_ar++; t_ar = cyc; cap_araddr = araddr; ar_owed = 1'b0; r_owed = 1'b1;
            end
            if (wr_phase && !aw_owed && !w_owed) begin
               wr_phase = 1'b0; b_owed = 1'b1;
            end
            if (cmd_valid && cmd_ready === 1'b1) begin
               n_cmd++; t_cmd = cyc; idle_m = 1'b0;
               cur_addr = cmd_addr; cur_wdata = cmd_wdata; cur_wstrb = cmd_wstrb;
               if (cmd_write) begin
                  aw_owed = 1'b1; w_owed = 1'b1; wr_phase = 1'b1;
               end else begin
                  ar_owed = 1'b1;
               end
            end
         end
      end
   end

   // On the falling edge: compare DUT against the model, then drive slave/consumer inputs.
   initial begin : compare_and_drive
      int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, rsp_cnt = 0;
      forever begin
         @(negedge clk);
         if (started) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(idle_m));
            chk("awvalid", 32'(awvalid), 32'(aw_owed));
            chk("wvalid", 32'(wvalid), 32'(w_owed));
            chk("arvalid", 32'(arvalid), 32'(ar_owed));
            chk("bready", 32'(bready), 32'(b_owed));
            chk("rready", 32'(rready), 32'(r_owed));
            chk("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
            if (awvalid === 1'b1) chk("awaddr", 32'(awaddr), 32'(cur_addr));
            if (wvalid === 1'b1) begin
               chk("wdata", wdata, cur_wdata);
               chk("wstrb", 32'(wstrb), 32'(cur_wstrb));
            end
            if (arvalid === 1'b1) chk("araddr", 32'(araddr), 32'(cur_addr));
            if (rsp_valid === 1'b1) begin
               chk("rsp_write", 32'(rsp_write), 32'(exp_write));
               chk("rsp_rdata", rsp_rdata, exp_rdata);
               chk("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
            end
         end
         if (awvalid === 1'b1) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
         else begin awready = 1'b0; aw_cnt = 0; end
         if (wvalid === 1'b1) begin wready = (w_cnt >= w_delay); w_cnt++; end
         else begin wready = 1'b0; w_cnt = 0; end
         if (arvalid === 1'b1) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
         else begin arready = 1'b0; ar_cnt = 0; end
         bresp = bresp_cfg;
         if (b_owed) begin bvalid = (b_cnt >= b_delay); b_cnt++; end
         else begin bvalid = spur; b_cnt = 0; end
         if (r_owed) begin
            rvalid = (r_cnt >= r_delay); rdata = rdata_cfg; rresp = rresp_cfg; r_cnt++;
         end else begin
            rvalid = spur; rdata = 32'hBAD0BAD0; rresp = 2'b11; r_cnt = 0;
         end
         if (rsp_valid === 1'b1) begin rsp_ready = (rsp_cnt >= rsp_delay); rsp_cnt++; end
         else begin rsp_ready = 1'b0; rsp_cnt = 0; end
      end
   end

   task automatic run_txn(input logic w, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit keep);
      int c0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      c0 = n_cmd;
      for (int k = 0; k < 100 && n_cmd == c0; k++) @(negedge clk);
      chk("cmd_accept", 32'(n_cmd != c0), 32'd1);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      for (int k = 0; k < 200 && n_rsp < target; k++) @(negedge clk);
      chk("rsp_done", 32'(n_rsp >= target), 32'd1);
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int tc, tc1, tc2, r0, a0, w0, ar0, b0, rr0, c0, h0, hw0, hr0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_valids", 32'({awvalid, wvalid, arvalid}), 32'd0);
      chk("reset_readies", 32'({bready, rready}), 32'd0);

      // 1: simple write, always-ready slave
      r0 = n_rsp;
      run_txn(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 1'b0);
      tc = t_cmd;
      wait_rsp(r0 + 1);
      chk("t1_aw_lat", 32'(t_aw - tc), 32'd1);
      chk("t1_w_lat", 32'(t_w - tc), 32'd1);
      chk("t1_b_lat", 32'(t_b - tc), 32'd2);
      chk("t1_rsp_lat", 32'(t_rsp - tc), 32'd3);
      chk("t1_awaddr", 32'(cap_awaddr), 32'h4);
      chk("t1_wdata", cap_wdata, 32'hDEADBEEF);
      chk("t1_wstrb", 32'(cap_wstrb), 32'hF);
      chk("t1_rsp_write", 32'(cap_rsp_write), 32'd1);
      chk("t1_rsp_resp", 32'(cap_rsp_resp), 32'd0);
      chk("t1_rsp_rdata", cap_rsp_rdata, 32'd0);
      chk("t1_cmd_ready_again", 32'(cmd_ready), 32'd1);

      // 2: simple read
      rdata_cfg = 32'h12345678; rresp_cfg = 2'd0;
      r0 = n_rsp;
      run_txn(1'b0, 4'h8, 32'h0, 4'h0, 1'b0);
      tc = t_cmd;
      wait_rsp(r0 + 1);
      chk("t2_ar_lat", 32'(t_ar - tc), 32'd1);
      chk("t2_r_lat", 32'(t_r - tc), 32'd2);
      chk("t2_rsp_lat", 32'(t_rsp - tc), 32'd3);
      chk("t2_araddr", 32'(cap_araddr), 32'h8);
      chk("t2_rdata", cap_rsp_rdata, 32'h12345678);
      chk("t2_resp", 32'(cap_rsp_resp), 32'd0);
      chk("t2_write", 32'(cap_rsp_write), 32'd0);

      // 3: awready delayed 3 cycles, W first
      aw_delay = 3;
      r0 = n_rsp; h0 = aw_hi; hw0 = w_hi;
      run_txn(1'b1, 4'hA, 32'hA5A5_5A5A, 4'h6, 1'b0);
      tc = t_cmd;
      wait_rsp(r0 + 1);
      aw_delay = 0;
      chk("t3_aw_lat", 32'(t_aw - tc), 32'd4);
      chk("t3_w_lat", 32'(t_w - tc), 32'd1);
      chk("t3_b_lat", 32'(t_b - tc), 32'd5);
      chk("t3_aw_cycles", 32'(aw_hi - h0), 32'd4);
      chk("t3_w_cycles", 32'(w_hi - hw0), 32'd1);
      chk("t3_awaddr", 32'(cap_awaddr), 32'hA);

      // 4: read with SLVERR, consumer stalls 5 cycles
      rdata_cfg = 32'hCAFEF00D; rresp_cfg = 2'd2; rsp_delay = 5;
      r0 = n_rsp; hr0 = rsp_hi;
      run_txn(1'b0, 4'h1, 32'h0, 4'h0, 1'b0);
      tc = t_cmd;
      wait_rsp(r0 + 1);
      rsp_delay = 0;
      chk("t4_rsp_lat", 32'(t_rsp - tc), 32'd8);
      chk("t4_rsp_cycles", 32'(rsp_hi - hr0), 32'd6);
      chk("t4_resp", 32'(cap_rsp_resp), 32'd2);
      chk("t4_rdata", cap_rsp_rdata, 32'hCAFEF00D);

      // 5: back-to-back write then read with cmd_valid held high
      rdata_cfg = 32'h55AA00FF; rresp_cfg = 2'd0;
      r0 = n_rsp; a0 = n_aw; w0 = n_w; ar0 = n_ar; b0 = n_b; rr0 = n_r; c0 = n_cmd;
      run_txn(1'b1, 4'hC, 32'h11223344, 4'h3, 1'b1);
      tc1 = t_cmd;
      run_txn(1'b0, 4'h2, 32'h0, 4'h0, 1'b0);
      tc2 = t_cmd;
      chk("t5_second_after_rsp", 32'(tc2 - t_rsp), 32'd1);
      chk("t5_cmd_spacing", 32'(tc2 - tc1), 32'd4);
      wait_rsp(r0 + 2);
      chk("t5_n_cmd", 32'(n_cmd - c0), 32'd2);
      chk("t5_n_aw", 32'(n_aw - a0), 32'd1);
      chk("t5_n_w", 32'(n_w - w0), 32'd1);
      chk("t5_n_ar", 32'(n_ar - ar0), 32'd1);
      chk("t5_n_b", 32'(n_b - b0), 32'd1);
      chk("t5_n_r", 32'(n_r - rr0), 32'd1);
      chk("t5_rdata", cap_rsp_rdata, 32'h55AA00FF);

      // 6: reset while AW is stalled
      aw_delay = 10;
      run_txn(1'b1, 4'h6, 32'h0000_0066, 4'hF, 1'b0);
      @(negedge clk);
      chk("t6_pre_awvalid", 32'(awvalid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      aw_delay = 0;
      chk("t6_valids", 32'({awvalid, wvalid, arvalid}), 32'd0);
      chk("t6_readies", 32'({bready, rready}), 32'd0);
      chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);

      // 7: AW first, W delayed 2, DECERR with delayed B
      w_delay = 2; b_delay = 2; bresp_cfg = 2'd3;
      r0 = n_rsp;
      run_txn(1'b1, 4'hF, 32'h0BADCAFE, 4'h9, 1'b0);
      tc = t_cmd;
      wait_rsp(r0 + 1);
      w_delay = 0; b_delay = 0; bresp_cfg = 2'd0;
      chk("t7_aw_lat", 32'(t_aw - tc), 32'd1);
      chk("t7_w_lat", 32'(t_w - tc), 32'd3);
      chk("t7_b_lat", 32'(t_b - tc), 32'd6);
      chk("t7_rsp_lat", 32'(t_rsp - tc), 32'd7);
      chk("t7_resp", 32'(cap_rsp_resp), 32'd3);
      chk("t7_wdata", cap_wdata, 32'h0BADCAFE);

      // 8: spurious B/R while idle and while waiting for AR
      spur = 1'b1;
      repeat (3) @(negedge clk);
      chk("t8_idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t8_idle_cmd_ready", 32'(cmd_ready), 32'd1);
      ar_delay = 2; rdata_cfg = 32'h0F0F1234; rresp_cfg = 2'd1;
      r0 = n_rsp;
      run_txn(1'b0, 4'h3, 32'h0, 4'h0, 1'b0);
      tc = t_cmd;
      wait_rsp(r0 + 1);
      spur = 1'b0; ar_delay = 0;
      chk("t8_ar_lat", 32'(t_ar - tc), 32'd3);
      chk("t8_r_lat", 32'(t_r - tc), 32'd4);
      chk("t8_rdata", cap_rsp_rdata, 32'h0F0F1234);
      chk("t8_resp", 32'(cap_rsp_resp), 32'd1);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
